// File: rtl/spiflash_pkg.sv
// Shared constants and state type for the SPI NOR flash host.
package spiflash_pkg;

    localparam logic [7:0] SPI_CMD_READ   = 8'h01;
    localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
    localparam int         SPI_ADR_BITS   = 32;
    localparam int         SPI_FRAME_BITS = 48;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spihoststate_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter producing SCK and single-cycle edge strobes.
// The strobes mark the clk cycle whose closing edge makes SCK rise or fall.
module spi_sck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic SCK,
    output logic RiseEn,
    output logic FallEn,
    output logic SampleEn
);

    localparam int            HW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [HW-1:0] HMAX = HW'(DIV - 1);

    logic [HW-1:0] hcnt;
    logic          wrap;

    assign wrap = en && (hcnt == HMAX);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            hcnt <= '0;
            SCK  <= 1'b0;
        end else begin
            hcnt <= (hcnt == HMAX) ? '0 : hcnt + 1'b1;
            if (wrap)
                SCK <= ~SCK;
        end
    end

    assign RiseEn   = wrap && !SCK;
    assign FallEn   = wrap && SCK;
    // Last cycle of SCK-high: the flash output is settled and about to shift.
    assign SampleEn = FallEn;

endmodule

// File: rtl/spi_flash_host.sv
// SPI mode-0 host: one byte read or write per frame of {adr[31:0], cmd, data}.
// Optional SPI_FLASH_HOST_STATS_EN adds RdCount/WrCount completion counters.
//
//   state | meaning
//   IDLE  | waiting for a request, ReqReady high
//   SETUP | CS low, MOSI presents first bit, SCK low
//   SHIFT | 48 SCK periods
//   HOLD  | CS low after last SCK fall
//   GAP   | CS high minimum idle time
module spi_flash_host
    import spiflash_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic [SPI_ADR_BITS-1:0] ReqAdr,
    input  logic [7:0]              ReqWData,
    output logic                    RspValid,
    output logic [7:0]              RspRData,
    output logic                    SPICLK,
    output logic                    SPICS,
    output logic                    SPIMOSI,
    input  logic                    SPIMISO
`ifdef SPI_FLASH_HOST_STATS_EN
   ,output logic [15:0]             RdCount,
    output logic [15:0]             WrCount
`endif
);

    spihoststate_t             state, state_nxt;
    logic [15:0]               tcnt;
    logic [5:0]                bitcnt;
    logic [SPI_FRAME_BITS-1:0] shreg;
    logic [7:0]                rx;
    logic                      is_wr;
    logic                      accept, tc, last_bit, done;
    logic                      sck, sck_en, rise_en, fall_en, sample_en;

    spi_sck_gen #(.DIV(DIV)) u_sck (
        .clk      (clk),
        .reset    (reset),
        .en       (sck_en),
        .SCK      (sck),
        .RiseEn   (rise_en),
        .FallEn   (fall_en),
        .SampleEn (sample_en)
    );

    assign accept   = ReqValid && ReqReady;
    assign tc       = (tcnt == 16'd0);
    assign last_bit = fall_en && (bitcnt == 6'(SPI_FRAME_BITS - 1));
    assign done     = (state == HOLD) && tc;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = SETUP;
            SETUP:   if (tc)       state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = HOLD;
            HOLD:    if (tc)       state_nxt = GAP;
            GAP:     if (tc)       state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        SPICS    = 1'b1;
        ReqReady = 1'b0;
        sck_en   = 1'b0;
        case (state)
            IDLE:        ReqReady = !reset;
            SETUP, HOLD: SPICS    = 1'b0;
            SHIFT: begin
                SPICS  = 1'b0;
                sck_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Phase timer: loaded with length-1 on entry, state advances at terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else begin
            case (state)
                IDLE:    if (accept)   tcnt <= 16'(CS_SETUP - 1);
                SETUP:   if (!tc)      tcnt <= tcnt - 16'd1;
                SHIFT:   if (last_bit) tcnt <= 16'(CS_HOLD - 1);
                HOLD:    tcnt <= tc ? 16'(CS_IDLE - 1) : tcnt - 16'd1;
                GAP:     if (!tc)      tcnt <= tcnt - 16'd1;
                default: tcnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bitcnt   <= '0;
            rx       <= '0;
            is_wr    <= 1'b0;
            RspValid <= 1'b0;
            RspRData <= '0;
        end else begin
            RspValid <= done;
            if (accept) begin
                shreg  <= {ReqAdr, ReqWrite ? SPI_CMD_WRITE : SPI_CMD_READ,
                           ReqWrite ? ReqWData : 8'h00};
                bitcnt <= '0;
                is_wr  <= ReqWrite;
            end else if (fall_en) begin
                shreg  <= shreg << 1;
                bitcnt <= bitcnt + 6'd1;
            end
            if (sample_en && (bitcnt >= 6'd40))
                rx <= {rx[6:0], SPIMISO};
            if (done && !is_wr)
                RspRData <= rx;
        end
    end

`ifdef SPI_FLASH_HOST_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            RdCount <= '0;
            WrCount <= '0;
        end else if (done) begin
            if (is_wr)
                WrCount <= WrCount + 16'd1;
            else
                RdCount <= RdCount + 16'd1;
        end
    end
`endif

    // SCK may only rise while a frame is being shifted.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!rise_en || state == SHIFT);
    end

    // Shift register drains to zero by frame end, so MOSI idles low.
    assign SPIMOSI = shreg[SPI_FRAME_BITS-1];
    assign SPICLK  = sck;

endmodule

// File: tb/tb_spi_flash_host.sv
// Bench for spi_flash_host: DIV=2 and DIV=1 hosts, each on a behavioural SPI NOR flash.
module tb_spi_flash_host;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        valid0 = 1'b0, write0 = 1'b0, valid1 = 1'b0, write1 = 1'b0;
    logic [31:0] adr0 = '0, adr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        rdy0, rdy1, rspv0, rspv1;
    logic [7:0]  rdata0, rdata1;
    logic        sclk0, cs0, mosi0, miso0, sclk1, cs1, mosi1, miso1;
`ifdef SPI_FLASH_HOST_STATS_EN
    logic [15:0] rdcnt0, wrcnt0, rdcnt1, wrcnt1;
`endif

    spi_flash_host #(.DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) u_dut (
        .clk(clk), .reset(reset), .ReqValid(valid0), .ReqReady(rdy0), .ReqWrite(write0),
        .ReqAdr(adr0), .ReqWData(wdata0), .RspValid(rspv0), .RspRData(rdata0),
        .SPICLK(sclk0), .SPICS(cs0), .SPIMOSI(mosi0), .SPIMISO(miso0)
`ifdef SPI_FLASH_HOST_STATS_EN
       ,.RdCount(rdcnt0), .WrCount(wrcnt0)
`endif
    );

    spi_flash_host #(.DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) u_dut_div1 (
        .clk(clk), .reset(reset), .ReqValid(valid1), .ReqReady(rdy1), .ReqWrite(write1),
        .ReqAdr(adr1), .ReqWData(wdata1), .RspValid(rspv1), .RspRData(rdata1),
        .SPICLK(sclk1), .SPICS(cs1), .SPIMOSI(mosi1), .SPIMISO(miso1)
`ifdef SPI_FLASH_HOST_STATS_EN
       ,.RdCount(rdcnt1), .WrCount(wrcnt1)
`endif
    );

    // Flash model: sample MOSI on rise; read data loads on the 41st rise and shifts on falls.
    for (genvar g = 0; g < 2; g++) begin : g_fl
        wire sclk = (g == 0) ? sclk0 : sclk1;
        wire cs   = (g == 0) ? cs0 : cs1;
        wire mosi = (g == 0) ? mosi0 : mosi1;
        logic        miso = 1'b0;
        logic [7:0]  mem [0:4095];
        logic [47:0] sr = '0;
        logic [7:0]  tx = '0;
        int          rises = 0;
        int          last_rises = 0;
        logic [47:0] last_frame = '0;

        initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        always @(negedge cs) rises = 0;
        always @(posedge cs) begin
            last_rises = rises;
            last_frame = sr;
        end
        always @(posedge sclk) begin
            if (!cs) begin
                if (rises == 40 && sr[7:0] == 8'h01) begin
                    tx   = mem[sr[19:8]];
                    miso = tx[7];
                end
                sr = {sr[46:0], mosi};
                rises++;
                if (rises == 48 && sr[15:8] == 8'h02)
                    mem[sr[27:16]] = sr[7:0];
            end
        end
        always @(negedge sclk) begin
            if (!cs && rises > 40 && rises < 48) begin
                tx   = tx << 1;
                miso = tx[7];
            end
        end
    end

    assign miso0 = g_fl[0].miso;
    assign miso1 = g_fl[1].miso;

    logic [1:0] rdy_v, rsp_v;
    assign rdy_v = {rdy1, rdy0};
    assign rsp_v = {rspv1, rspv0};

    int nvec = 0;
    int nerr = 0;

    int cs_hi_run = 0;
    int last_cs_gap = 0;
    always @(negedge clk) begin
        if (cs0 === 1'b1) begin
            cs_hi_run++;
        end else begin
            if (cs_hi_run != 0) last_cs_gap = cs_hi_run;
            cs_hi_run = 0;
        end
    end

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [47:0] frame_of(input int k);
        return (k == 0) ? g_fl[0].last_frame : g_fl[1].last_frame;
    endfunction

    function automatic int rises_of(input int k);
        return (k == 0) ? g_fl[0].last_rises : g_fl[1].last_rises;
    endfunction

    task automatic drive(input int k, input logic v, input logic wr, input logic [31:0] adr, input logic [7:0] wd);
        if (k == 0) begin
            valid0 = v; write0 = wr; adr0 = adr; wdata0 = wd;
        end else begin
            valid1 = v; write1 = wr; adr1 = adr; wdata1 = wd;
        end
    endtask

    task automatic set_valid(input int k, input logic v);
        if (k == 0) valid0 = v;
        else        valid1 = v;
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!rdy_v[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Latency counts negedges after the accept edge; the accept cycle itself is cycle 0.
    task automatic do_txn(input int k, input logic wr, input logic [31:0] adr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output bit ok);
        @(negedge clk);
        drive(k, 1'b1, wr, adr, wd);
        wait_ready(k);
        @(posedge clk);
        #1;
        set_valid(k, 1'b0);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (rsp_v[k]) ok = 1'b1;
        end
        rd = (k == 0) ? rdata0 : rdata1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
    } vec_t;

    localparam int LAT2 = 1 + 2 + 96 * 2 + 2;
    localparam int LAT1 = 1 + 2 + 96 * 1 + 2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt [8];
        logic [7:0]  rd;
        int          lat, n, busy_bad, gap_wait, n_rsp;
        bit          ok;

        vt[0] = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vt[2] = '{1'b1, 32'h1234_5678, 8'h3C, 8'hA5};
        vt[3] = '{1'b0, 32'h1234_5678, 8'h00, 8'h3C};
        vt[4] = '{1'b1, 32'h0000_0020, 8'hFF, 8'h3C};
        vt[5] = '{1'b0, 32'h0000_0020, 8'h00, 8'hFF};
        vt[6] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vt[7] = '{1'b1, 32'h0000_0030, 8'h00, 8'hA5};

        // Reset state, with a request held during reset that must be ignored.
        reset  = 1'b1;
        valid0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs", 0, cs0, 1);
        chk("rst_sclk", 0, sclk0, 0);
        chk("rst_mosi", 0, mosi0, 0);
        chk("rst_ready", 0, rdy0, 0);
        chk("rst_rspv", 0, rspv0, 0);
        chk("rst_rdata", 0, rdata0, 0);
        valid0 = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 0, rdy0, 1);
        chk("cs_after_rst", 0, cs0, 1);

        for (int i = 0; i < 8; i++) begin
            do_txn(0, vt[i].wr, vt[i].adr, vt[i].wd, rd, lat, ok);
            chk("rsp_seen", i, ok, 1);
            chk("latency", i, lat, LAT2);
            chk("rdata", i, rd, vt[i].exp_rd);
            chk("frame", i, frame_of(0),
                {vt[i].adr, vt[i].wr ? 8'h02 : 8'h01, vt[i].wr ? vt[i].wd : 8'h00});
            chk("rises", i, rises_of(0), 48);
        end

        // Back-to-back: ReqValid stays high, second request swapped in after first accept.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0000_0040, 8'h11);
        wait_ready(0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 32'h0000_0040, 8'h00);
        busy_bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (rdy0) busy_bad++;
        end while (!rspv0 && n < 2000);
        chk("b2b_rsp1", 0, rspv0, 1);
        chk("b2b_rsp1_lat", 0, n, LAT2);
        chk("b2b_rsp1_rdata", 0, rdata0, 8'hA5);
        gap_wait = 0;
        while (!rdy0 && gap_wait < 100) begin
            @(negedge clk);
            gap_wait++;
        end
        chk("b2b_gap_ready", 0, gap_wait, 4);
        @(posedge clk);
        #1;
        set_valid(0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (rdy0) busy_bad++;
        end while (!rspv0 && n < 2000);
        chk("b2b_rsp2", 0, rspv0, 1);
        chk("b2b_rsp2_lat", 0, n, LAT2);
        chk("b2b_rsp2_rdata", 0, rdata0, 8'h11);
        chk("b2b_ready_busy", 0, busy_bad, 0);
        chk("b2b_cs_gap_ge4", 0, last_cs_gap >= 4, 1);

        // Reset at bit 20 of a write to 0x10: frame discarded, location keeps 0xA5.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0000_0010, 8'h5A);
        wait_ready(0);
        @(posedge clk);
        #1;
        set_valid(0, 1'b0);
        n = 0;
        while (g_fl[0].rises < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit20", 0, g_fl[0].rises, 20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cs", 0, cs0, 1);
        chk("midrst_sclk", 0, sclk0, 0);
        chk("midrst_mosi", 0, mosi0, 0);
        chk("midrst_ready", 0, rdy0, 0);
        n_rsp = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            if (rspv0) n_rsp++;
        end
        chk("midrst_no_rsp", 0, n_rsp, 0);
        do_txn(0, 1'b0, 32'h0000_0010, 8'h00, rd, lat, ok);
        chk("midrst_read_ok", 0, ok, 1);
        chk("midrst_read", 0, rd, 8'hA5);

        // DIV=1 host: SCK = clk/2, so the shift phase is 96 cycles.
        do_txn(1, 1'b1, 32'h0000_07FF, 8'h81, rd, lat, ok);
        chk("div1_wr_ok", 0, ok, 1);
        chk("div1_wr_lat", 0, lat, LAT1);
        chk("div1_wr_rises", 0, rises_of(1), 48);
        do_txn(1, 1'b0, 32'h0000_07FF, 8'h00, rd, lat, ok);
        chk("div1_rd_ok", 0, ok, 1);
        chk("div1_rd_lat", 0, lat, LAT1);
        chk("div1_rd_data", 0, rd, 8'h81);
        chk("div1_rd_frame", 0, frame_of(1), {32'h0000_07FF, 8'h01, 8'h00});

`ifdef SPI_FLASH_HOST_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_txn(0, 1'b1, 32'h0000_0050 + 32'(i), 8'(i + 1), rd, lat, ok);
        end
        for (int i = 0; i < 2; i++) begin
            do_txn(0, 1'b0, 32'h0000_0050 + 32'(i), 8'h00, rd, lat, ok);
            chk("stats_rd_data", i, rd, 8'(i + 1));
        end
        @(negedge clk);
        chk("stats_wr", 0, wrcnt0, 16'd3);
        chk("stats_rd", 0, rdcnt0, 16'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("stats_wr_rst", 0, wrcnt0, 16'd0);
        chk("stats_rd_rst", 0, rdcnt0, 16'd0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
